// File: rtl/tick_irq_pkg.sv
// tick_irq_pkg: shared constants for the tick/interrupt controller.
//   Register word offsets (PADDR[4:2]), counter widths, source limit.
package tick_irq_pkg;
  localparam logic [2:0] OFS_PENDING = 3'd0;
  localparam logic [2:0] OFS_ENABLE  = 3'd1;
  localparam logic [2:0] OFS_TICKCNT = 3'd2;
  localparam logic [2:0] OFS_OVERRUN = 3'd3;
  localparam logic [2:0] OFS_STATUS  = 3'd4;
  localparam logic [2:0] OFS_SWSET   = 3'd5;

  localparam int OVR_W    = 8;
  localparam int CNT_W    = 32;
  localparam int NSRC_MAX = 32;
endpackage

// File: rtl/irq_edge_sync.sv
// irq_edge_sync: two-flop synchronizer plus previous-value flop for one
// asynchronous level interrupt; emits a one-cycle rising-edge pulse.
//   clk, rst   : clock, async active-high reset (clears all three flops)
//   async_i    : raw level input, asynchronous to clk
//   edge_o     : high for exactly one cycle after a synchronized rise
module irq_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic edge_o
);
  logic meta_q, sync_q, prev_q;
  logic meta_d, sync_d, prev_d;

  always_comb begin
    meta_d = async_i;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // A level held high yields one pulse; it must be seen low before re-arming.
  assign edge_o = sync_q & ~prev_q;
endmodule

// File: rtl/tick_irq_ctrl.sv
// tick_irq_ctrl: APB3 interrupt latch and tick accounting.
//   PCLK/PRESET          : clock, async active-high reset
//   PSEL..PWDATA, PRDATA : APB3 slave, zero wait state (PREADY=1, PSLVERR=0)
//   IRQ_IN[NSRC-1:0]     : async level interrupts, bit 0 = timer TIMINT
//   IRQ                  : registered OR of enabled pending bits
// NSRC must lie in 1..NSRC_MAX.
module tick_irq_ctrl
  import tick_irq_pkg::*;
#(
  parameter int NSRC = 4
) (
  input  logic            PCLK,
  input  logic            PRESET,
  input  logic            PSEL,
  input  logic            PENABLE,
  input  logic            PWRITE,
  input  logic [4:2]      PADDR,
  input  logic [31:0]     PWDATA,
  output logic [31:0]     PRDATA,
  output logic            PREADY,
  output logic            PSLVERR,
  input  logic [NSRC-1:0] IRQ_IN,
  output logic            IRQ
);
  logic [NSRC-1:0]  edge_w;
  logic [NSRC-1:0]  pending_q, pending_d, enable_q, enable_d;
  logic [NSRC-1:0]  w1c_mask, swset_mask;
  logic [CNT_W-1:0] tickcnt_q, tickcnt_d, tick_base;
  logic [OVR_W-1:0] overrun_q, overrun_d;
  logic             irq_q, irq_d;
  logic             wr, ovr_evt;

  for (genvar g = 0; g < NSRC; g++) begin : g_sync
    irq_edge_sync u_sync (
      .clk    (PCLK),
      .rst    (PRESET),
      .async_i(IRQ_IN[g]),
      .edge_o (edge_w[g])
    );
  end

  assign wr      = PSEL & PENABLE & PWRITE;
  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;
  assign IRQ     = irq_q;

  always_comb begin
    w1c_mask   = (wr && PADDR == OFS_PENDING) ? PWDATA[NSRC-1:0] : '0;
    swset_mask = (wr && PADDR == OFS_SWSET)   ? PWDATA[NSRC-1:0] : '0;
    // Sets are ORed in after the clear so a coincident event is never lost.
    pending_d  = (pending_q & ~w1c_mask) | edge_w | swset_mask;
    enable_d   = (wr && PADDR == OFS_ENABLE) ? PWDATA[NSRC-1:0] : enable_q;

    // A load and a tick in the same cycle both take effect.
    tick_base  = (wr && PADDR == OFS_TICKCNT) ? PWDATA : tickcnt_q;
    tickcnt_d  = tick_base + CNT_W'(edge_w[0]);

    // Lost tick: previous tick still pending and not being acknowledged now.
    ovr_evt    = edge_w[0] & pending_q[0] & ~w1c_mask[0];
    overrun_d  = overrun_q;
    if (wr && PADDR == OFS_OVERRUN)
      overrun_d = '0;
    else if (ovr_evt && overrun_q != '1)
      overrun_d = overrun_q + OVR_W'(1);

    // Uses next-state values so IRQ tracks a register write on the same edge.
    irq_d      = |(pending_d & enable_d);
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      pending_q <= '0;
      enable_q  <= '0;
      tickcnt_q <= '0;
      overrun_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      enable_q  <= enable_d;
      tickcnt_q <= tickcnt_d;
      overrun_q <= overrun_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      case (PADDR)
        OFS_PENDING: PRDATA = 32'(pending_q);
        OFS_ENABLE:  PRDATA = 32'(enable_q);
        OFS_TICKCNT: PRDATA = tickcnt_q;
        OFS_OVERRUN: PRDATA = 32'(overrun_q);
        OFS_STATUS:  PRDATA = 32'(pending_q & enable_q);
        default:     PRDATA = '0;
      endcase
    end
  end
endmodule
